// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings for the program-counter unit (next-PC opcodes,
// RV32I branch funct3 values, FSM states, default reset PC).
package pc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JAL    = 2'd2,
    NPC_JALR   = 2'd3
  } npc_op_e;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/br_cond.sv
// br_cond: decodes the RV32I branch funct3 against the ALU flags of rs1-rs2.
module br_cond
  import pc_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic       zf,
  input  logic       sf,
  input  logic       cf,
  input  logic       of,
  output logic       cond
);

  // Branch condition select; reserved funct3 values never branch.
  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_BEQ:  cond = zf;
      BR_BNE:  cond = ~zf;
      BR_BLT:  cond = sf ^ of;
      BR_BGE:  cond = ~(sf ^ of);
      BR_BLTU: cond = cf;
      BR_BGEU: cond = ~cf;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter register with BOOT/RUN/STALL/HALT control FSM.
// Optional branch statistics counters are built when PC_UNIT_BR_STAT_EN is defined.
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter bit          HALT_ON_ECALL = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic [2:0]  br_type,
  input  logic        zf,
  input  logic        sf,
  input  logic        cf,
  input  logic        of,
  input  logic [31:0] imm,
  input  logic [31:0] alu_c,
  input  logic        ecall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        taken,
  output logic        halted
`ifdef PC_UNIT_BR_STAT_EN
  ,
  output logic [31:0] br_cnt,
  output logic [31:0] br_taken_cnt
`endif
);

  state_e      state, state_nx;
  npc_op_e     op;
  logic        cond;
  logic        redirect;
  logic        pc_load;
  logic [31:0] next_pc;

  assign op       = npc_op_e'(npc_op);
  assign pc_plus4 = pc + 32'd4;
  assign halted   = (state == ST_HALT);

  br_cond u_br_cond (
    .br_type (br_type),
    .zf      (zf),
    .sf      (sf),
    .cf      (cf),
    .of      (of),
    .cond    (cond)
  );

  // Target selection and redirect decode for the current instruction.
  always_comb begin
    redirect = 1'b0;
    next_pc  = pc_plus4;
    case (op)
      NPC_SEQ:    begin redirect = 1'b0; next_pc = pc_plus4; end
      NPC_BRANCH: begin redirect = cond; next_pc = cond ? (pc + imm) : pc_plus4; end
      NPC_JAL:    begin redirect = 1'b1; next_pc = pc + imm; end
      NPC_JALR:   begin redirect = 1'b1; next_pc = {alu_c[31:1], 1'b0}; end
      default:    begin redirect = 1'b0; next_pc = pc_plus4; end
    endcase
  end

  assign taken = (state == ST_RUN) ? redirect : 1'b0;

  // Next-state logic; leaving STALL only returns to RUN so the held
  // instruction is re-evaluated there (stall also masks a pending ecall).
  always_comb begin
    state_nx = state;
    pc_load  = 1'b0;
    case (state)
      ST_BOOT:  state_nx = ST_RUN;
      ST_RUN: begin
        if (stall)                       state_nx = ST_STALL;
        else if (HALT_ON_ECALL && ecall) state_nx = ST_HALT;
        else                             pc_load  = 1'b1;
      end
      ST_STALL: if (!stall) state_nx = ST_RUN;
      ST_HALT:  state_nx = ST_HALT;
      default:  state_nx = ST_BOOT;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      if (pc_load) pc <= next_pc;
    end
  end

`ifdef PC_UNIT_BR_STAT_EN
  // Saturating counters of retired and taken branches.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      br_cnt       <= '0;
      br_taken_cnt <= '0;
    end else if (pc_load && op == NPC_BRANCH) begin
      if (br_cnt != '1) br_cnt <= br_cnt + 32'd1;
      if (cond && br_taken_cnt != '1) br_taken_cnt <= br_taken_cnt + 32'd1;
    end
  end
`endif

endmodule
